ahb_sram_bridge: RTL and testbench
==================================

# ahb_sram_bridge

AHB-Lite slave that converts bus transfers from the core's master port into cycles on the single-port synchronous SRAM macro interface (`sram_cen`/`sram_wen`/`sram_ben`/`sram_addr`/`sram_din`/`sram_dout`). It sits directly downstream of the `top` AHB master port and directly upstream of the SRAM array. It replaces the behavioural memory slave in system builds.

- Write transfers complete with zero wait states.
- A read issued right after a write stalls one cycle.
- Out-of-range, misaligned or oversized transfers return a two-cycle ERROR response.

## Interface
Parameters:
- `MEM_BYTES`, 4194304: SRAM size in bytes (power of two). Byte addresses at or above this value are out of range.

Ports:
- `HCLK` in 1: the only clock. All state updates on its rising edge.
- `HRESET` in 1: reset, synchronous, active-high.
- `HSEL` in 1: slave select.
- `HADDR` in 32: byte address (address phase).
- `HTRANS` in 2: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `HWRITE` in 1: 1 = write.
- `HSIZE` in 3: 0 byte, 1 half, 2 word.
- `HWDATA` in 32: write data (data phase).
- `HREADY` in 1: bus ready; an address phase is accepted only when it is high.
- `HRDATA` out 32: read data.
- `HREADYOUT` out 1: slave ready.
- `HRESP` out 1: 0 OKAY, 1 ERROR.
- `sram_cen` out 1: chip enable, active-low.
- `sram_wen` out 1: write enable, active-low.
- `sram_ben` out 4: byte enables, active-low; bit i enables lane `[8i+7:8i]`.
- `sram_addr` out 32: word-aligned byte address; bits [1:0] are always 0.
- `sram_din` out 32: SRAM write data.
- `sram_dout` in 32: SRAM read data, registered by the SRAM one cycle after a read cycle.

## Operation
Transfer acceptance:
- Accept = `HSEL & HTRANS[1] & HREADY`.
- IDLE and BUSY transfers get an OKAY response with zero wait states and never touch the SRAM.

Error checks, performed at accept:
- Error if any of the following holds: `HSIZE > 2`; a half transfer with `HADDR[0]=1`; a word transfer with `HADDR[1:0]≠0`; `HADDR >= MEM_BYTES`.
- An error transfer never touches the SRAM and goes to ERR1.

Byte enables, little-endian:
- Byte: clear `ben[HADDR[1:0]]`.
- Half: clear `ben[2*HADDR[1] +: 2]`.
- Word: `ben = 4'h0`.
- Reads use the same `ben`.

The FSM state describes the current data phase:
- **IDLE**
  - Outputs: `HREADYOUT=1`, `HRESP=0`, `HRDATA=0`.
  - Accepted read: the SRAM read is driven combinationally this cycle from `HADDR`; next state RD.
  - Accepted write: latch address/ben/size; next state WR.
  - Error: next state ERR1.
- **WR**
  - Outputs: `HREADYOUT=1`.
  - SRAM cycle: `cen=0`, `wen=0`, latched addr/ben, `sram_din = HWDATA`.
  - Accepted read: the port is busy, so latch the read; next state RDS.
  - Accepted write: next state WR.
  - Error: next state ERR1.
  - Otherwise: next state IDLE.
- **RDS** (read stall)
  - Outputs: `HREADYOUT=0`.
  - SRAM cycle: read from the latched addr.
  - Next state: RD. No new transfer can be accepted because `HREADY` is low.
- **RD**
  - Outputs: `HREADYOUT=1`, `HRDATA = sram_dout`.
  - Next transfer: handled as in IDLE (read issued this cycle, next state RD).
- **ERR1**
  - Outputs: `HREADYOUT=0`, `HRESP=1`.
  - Next state: ERR2.
- **ERR2**
  - Outputs: `HREADYOUT=1`, `HRESP=1`.
  - Next transfer: handled as in IDLE (the master may cancel by driving IDLE).

SRAM port rules:
- No SRAM access in any other cycle: `cen=1`, `wen=1`, `ben=4'hF`, `sram_addr` holds its last value, `sram_din=0`.
- There is never more than one SRAM access per cycle.
- No read/write forwarding is needed: RDS always follows the committing WR edge.

## Timing
- Reset:
  - While `HRESET=1`: `sram_cen=1` (gated combinationally), `sram_wen=1`, `sram_ben=4'hF`, `sram_din=0`, `HRESP=0`, `HRDATA=0`.
  - At the first edge with `HRESET=1`: state goes to IDLE, `HREADYOUT=1`, `sram_addr=0`.
  - A write whose data phase coincides with reset is dropped.
  - A latched RDS read is discarded.
- Read latency:
  - Read after IDLE, RD or ERR2: data is valid in the data-phase cycle immediately following the address phase (0 wait states).
  - Read after WR: 1 wait state.
- Writes: data is committed at the rising edge ending the data phase.
- Back-to-back NONSEQ/SEQ streams sustain one transfer per cycle, except each write→read turnaround costs 1 cycle.
- HBURST is ignored; every beat is checked independently.

## Test plan
- Reset, then word write `0xDEADBEEF` to 0x100, then IDLE, then word read 0x100 → write cycle `sram_ben=0`, `sram_addr=0x100`; read returns `0xDEADBEEF` with 0 wait states.
- Byte writes `0x11`@0x201, `0x22`@0x202, then an immediate word read 0x200 → `ben=4'b1101` then `4'b1011`; read stalls exactly 1 cycle (RDS); `HRDATA[23:8] = 0x2211`.
- Half write `0xABCD`@0x302, then a back-to-back pipelined read of 0x300 → `ben=4'b0011`; `HRDATA[31:16] = 0xABCD`, with no forwarding error.
- Word read at 0x102, then half at 0x1, then word at `MEM_BYTES` → each gives `HREADYOUT` 0 then 1 with `HRESP=1` for both cycles; `sram_cen` stays 1 throughout.
- `HRESET` asserted during a WR data phase (write to 0x400 of 0x5A5A5A5A) → no SRAM write occurs; a later read of 0x400 returns the prior contents; all outputs are at reset values the next cycle.
- 16 alternating NONSEQ reads, with `HTRANS=BUSY` interleaved → BUSY gets OKAY, zero wait states and `cen=1`; every read completes in 1 cycle.

Source files
------------

// File: rtl/ahb_sram_bridge_if.sv
// AHB-Lite bus bundle between the core's master port and the SRAM bridge slave.
interface ahb_sram_bridge_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          HSEL;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [DW-1:0] HWDATA;
  logic          HREADY;
  logic [DW-1:0] HRDATA;
  logic          HREADYOUT;
  logic          HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_sram_bridge.sv
// AHB-Lite slave driving a single-port synchronous SRAM macro.
// Writes are zero-wait; a read that follows a write stalls one cycle.
module ahb_sram_bridge #(
  parameter int unsigned MEM_BYTES = 32'd4194304
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  ahb_sram_bridge_if.slave     ahb,
  output logic                 sram_cen,
  output logic                 sram_wen,
  output logic [3:0]           sram_ben,
  output logic [31:0]          sram_addr,
  output logic [31:0]          sram_din,
  input  logic [31:0]          sram_dout
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RDS, S_RD, S_ERR1, S_ERR2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [BW-1:0] ben_q, ben_d;
  logic [AW-1:0] sram_addr_q;

  logic          hreadyout_c;
  logic          accept_c;
  logic          err_c;
  logic [BW-1:0] ben_c;
  logic [AW-1:0] word_addr_c;
  logic          unused_trans0;

  assign unused_trans0 = ahb.HTRANS[0];

  // Only IDLE/WR/RD/ERR2 present HREADYOUT=1, so only they can take a new address phase.
  assign hreadyout_c = (state_q != S_RDS) && (state_q != S_ERR1);
  assign accept_c    = ahb.HSEL && ahb.HTRANS[1] && ahb.HREADY && hreadyout_c;
  assign word_addr_c = {ahb.HADDR[AW-1:2], 2'b00};

  assign err_c = (ahb.HSIZE > 3'd2)
              || ((ahb.HSIZE == 3'd1) && ahb.HADDR[0])
              || ((ahb.HSIZE == 3'd2) && (ahb.HADDR[1:0] != 2'b00))
              || (ahb.HADDR >= AW'(MEM_BYTES));

  // Little-endian active-low lane enables
  always_comb begin
    unique case (ahb.HSIZE)
      3'd0:    ben_c = ~(BW'(1) << ahb.HADDR[1:0]);
      3'd1:    ben_c = ahb.HADDR[1] ? 4'b0011 : 4'b1100;
      default: ben_c = 4'h0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ben_d     = ben_q;
    sram_cen  = 1'b1;
    sram_wen  = 1'b1;
    sram_ben  = 4'hF;
    sram_addr = sram_addr_q;
    sram_din  = '0;

    unique case (state_q)
      S_WR: begin
        sram_cen  = 1'b0;
        sram_wen  = 1'b0;
        sram_ben  = ben_q;
        sram_addr = addr_q;
        sram_din  = ahb.HWDATA;
      end
      S_RDS: begin
        sram_cen  = 1'b0;
        sram_ben  = ben_q;
        sram_addr = addr_q;
        state_d   = S_RD;
      end
      S_ERR1:  state_d = S_ERR2;
      default: ;
    endcase

    if (accept_c) begin
      if (err_c) begin
        state_d = S_ERR1;
      end else if (ahb.HWRITE || (state_q == S_WR)) begin
        // Writes, and reads colliding with a committing write, are latched
        state_d = ahb.HWRITE ? S_WR : S_RDS;
        addr_d  = word_addr_c;
        ben_d   = ben_c;
      end else begin
        state_d   = S_RD;
        sram_cen  = 1'b0;
        sram_ben  = ben_c;
        sram_addr = word_addr_c;
      end
    end else if (hreadyout_c) begin
      state_d = S_IDLE;
    end

    // Reset suppresses any access, including a write in its data phase
    if (HRESET) begin
      sram_cen  = 1'b1;
      sram_wen  = 1'b1;
      sram_ben  = 4'hF;
      sram_addr = sram_addr_q;
      sram_din  = '0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      ben_q       <= 4'hF;
      sram_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ben_q       <= ben_d;
      sram_addr_q <= sram_addr;
    end
  end

  assign ahb.HREADYOUT = hreadyout_c;
  assign ahb.HRESP     = !HRESET && ((state_q == S_ERR1) || (state_q == S_ERR2));
  assign ahb.HRDATA    = (!HRESET && (state_q == S_RD)) ? sram_dout : DW'(0);

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// Directed bench for ahb_sram_bridge with a behavioural SRAM macro model.
module tb_ahb_sram_bridge;

  localparam int unsigned MEM_BYTES = 32'd4194304;
  localparam logic [1:0]  T_IDLE    = 2'b00;
  localparam logic [1:0]  T_BUSY    = 2'b01;
  localparam logic [1:0]  T_NSEQ    = 2'b10;

  logic        HCLK;
  logic        HRESET;
  logic        sram_cen;
  logic        sram_wen;
  logic [3:0]  sram_ben;
  logic [31:0] sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout;

  int checks   = 0;
  int failures = 0;

  ahb_sram_bridge_if bus ();

  ahb_sram_bridge #(.MEM_BYTES(MEM_BYTES)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .ahb       (bus.slave),
    .sram_cen  (sram_cen),
    .sram_wen  (sram_wen),
    .sram_ben  (sram_ben),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  assign bus.HREADY = bus.HREADYOUT;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // SRAM macro model: 1K words, registered read data
  logic [31:0] mem [0:1023];
  logic [9:0]  widx;
  assign widx = sram_addr[11:2];

  always @(posedge HCLK) begin
    if (!sram_cen) begin
      if (!sram_wen) begin
        for (int b = 0; b < 4; b++)
          if (!sram_ben[b]) mem[widx][8*b +: 8] <= sram_din[8*b +: 8];
      end else begin
        sram_dout <= mem[widx];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic mid();
    @(negedge HCLK);
  endtask

  task automatic drive(input logic [1:0] trans, input logic wr, input logic [2:0] size,
                       input logic [31:0] addr);
    bus.HSEL   = 1'b1;
    bus.HTRANS = trans;
    bus.HWRITE = wr;
    bus.HSIZE  = size;
    bus.HADDR  = addr;
  endtask

  task automatic idle();
    drive(T_IDLE, 1'b0, 3'd0, 32'h0);
  endtask

  logic [31:0] err_addr [3];
  logic [2:0]  err_size [3];

  initial begin
    bus.HSEL   = 1'b0;
    bus.HTRANS = T_IDLE;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = 3'd0;
    bus.HADDR  = 32'h0;
    bus.HWDATA = 32'h0;
    HRESET     = 1'b1;
    err_addr[0] = 32'h102;     err_size[0] = 3'd2;
    err_addr[1] = 32'h1;       err_size[1] = 3'd1;
    err_addr[2] = MEM_BYTES;   err_size[2] = 3'd2;

    // Reset values
    step();
    mid();
    check_eq("rst_cen",   32'(sram_cen), 32'd1);
    check_eq("rst_wen",   32'(sram_wen), 32'd1);
    check_eq("rst_ben",   32'(sram_ben), 32'hF);
    check_eq("rst_din",   sram_din, 32'h0);
    check_eq("rst_resp",  32'(bus.HRESP), 32'd0);
    check_eq("rst_rdata", bus.HRDATA, 32'h0);
    check_eq("rst_ready", 32'(bus.HREADYOUT), 32'd1);
    check_eq("rst_addr",  sram_addr, 32'h0);

    // Word write then word read after IDLE
    step(); HRESET = 1'b0;
    drive(T_NSEQ, 1'b1, 3'd2, 32'h100);
    mid();  check_eq("t1_aph_cen", 32'(sram_cen), 32'd1);
    step(); idle(); bus.HWDATA = 32'hDEADBEEF;
    mid();
    check_eq("t1_wr_cen",  32'(sram_cen), 32'd0);
    check_eq("t1_wr_wen",  32'(sram_wen), 32'd0);
    check_eq("t1_wr_ben",  32'(sram_ben), 32'h0);
    check_eq("t1_wr_addr", sram_addr, 32'h100);
    check_eq("t1_wr_din",  sram_din, 32'hDEADBEEF);
    step(); bus.HWDATA = 32'h0; drive(T_NSEQ, 1'b0, 3'd2, 32'h100);
    mid();
    check_eq("t1_rd_cen",  32'(sram_cen), 32'd0);
    check_eq("t1_rd_wen",  32'(sram_wen), 32'd1);
    step(); idle();
    mid();
    check_eq("t1_rd_ready", 32'(bus.HREADYOUT), 32'd1);
    check_eq("t1_rd_data",  bus.HRDATA, 32'hDEADBEEF);

    // Byte writes then immediate word read: one stall cycle
    step(); drive(T_NSEQ, 1'b1, 3'd0, 32'h201);
    mid();
    step(); bus.HWDATA = 32'h0000_1100; drive(T_NSEQ, 1'b1, 3'd0, 32'h202);
    mid();  check_eq("t2_ben_b1", 32'(sram_ben), 32'hD);
    step(); bus.HWDATA = 32'h0022_0000; drive(T_NSEQ, 1'b0, 3'd2, 32'h200);
    mid();
    check_eq("t2_ben_b2",  32'(sram_ben), 32'hB);
    check_eq("t2_wr_ready", 32'(bus.HREADYOUT), 32'd1);
    step(); bus.HWDATA = 32'h0; idle();
    mid();
    check_eq("t2_rds_ready", 32'(bus.HREADYOUT), 32'd0);
    check_eq("t2_rds_cen",   32'(sram_cen), 32'd0);
    check_eq("t2_rds_wen",   32'(sram_wen), 32'd1);
    check_eq("t2_rds_addr",  sram_addr, 32'h200);
    step();
    mid();
    check_eq("t2_rd_ready", 32'(bus.HREADYOUT), 32'd1);
    check_eq("t2_rd_data",  32'(bus.HRDATA[23:8]), 32'h2211);

    // Half write then pipelined read of the same word
    step(); drive(T_NSEQ, 1'b1, 3'd1, 32'h302);
    mid();
    step(); bus.HWDATA = 32'hABCD_0000; drive(T_NSEQ, 1'b0, 3'd2, 32'h300);
    mid();  check_eq("t3_ben", 32'(sram_ben), 32'h3);
    step(); bus.HWDATA = 32'h0; idle();
    mid();  check_eq("t3_rds_ready", 32'(bus.HREADYOUT), 32'd0);
    step();
    mid();  check_eq("t3_rd_data", 32'(bus.HRDATA[31:16]), 32'hABCD);

    // Misaligned, misaligned half, out-of-range: two-cycle ERROR each
    for (int i = 0; i < 3; i++) begin
      step(); drive(T_NSEQ, 1'b0, err_size[i], err_addr[i]);
      mid();
      check_eq("t4_aph_cen", 32'(sram_cen), 32'd1);
      if (i > 0) begin
        check_eq("t4_err2_ready", 32'(bus.HREADYOUT), 32'd1);
        check_eq("t4_err2_resp",  32'(bus.HRESP), 32'd1);
      end
      step(); idle();
      mid();
      check_eq("t4_err1_ready", 32'(bus.HREADYOUT), 32'd0);
      check_eq("t4_err1_resp",  32'(bus.HRESP), 32'd1);
      check_eq("t4_err1_cen",   32'(sram_cen), 32'd1);
    end
    step();
    mid();
    check_eq("t4_last_ready", 32'(bus.HREADYOUT), 32'd1);
    check_eq("t4_last_resp",  32'(bus.HRESP), 32'd1);
    check_eq("t4_last_cen",   32'(sram_cen), 32'd1);

    // Reset during a write data phase drops the write
    step(); drive(T_NSEQ, 1'b1, 3'd2, 32'h400);
    mid();
    step(); bus.HWDATA = 32'h1234_5678; drive(T_NSEQ, 1'b1, 3'd2, 32'h400);
    mid();
    step(); bus.HWDATA = 32'h5A5A_5A5A; idle(); HRESET = 1'b1;
    mid();
    check_eq("t5_rst_cen",  32'(sram_cen), 32'd1);
    check_eq("t5_rst_resp", 32'(bus.HRESP), 32'd0);
    step(); HRESET = 1'b0; bus.HWDATA = 32'h0;
    mid();
    check_eq("t5_post_ready", 32'(bus.HREADYOUT), 32'd1);
    check_eq("t5_post_resp",  32'(bus.HRESP), 32'd0);
    check_eq("t5_post_rdata", bus.HRDATA, 32'h0);
    check_eq("t5_post_cen",   32'(sram_cen), 32'd1);
    check_eq("t5_post_ben",   32'(sram_ben), 32'hF);
    check_eq("t5_post_addr",  sram_addr, 32'h0);
    step(); drive(T_NSEQ, 1'b0, 3'd2, 32'h400);
    mid();
    step(); idle();
    mid();  check_eq("t5_rd_data", bus.HRDATA, 32'h1234_5678);

    // Back-to-back write stream, then reads interleaved with BUSY
    for (int i = 0; i <= 16; i++) begin
      step();
      bus.HWDATA = (i > 0) ? (32'hC0DE_0000 + 32'(i - 1)) : 32'h0;
      if (i < 16) drive(T_NSEQ, 1'b1, 3'd2, 32'h800 + 32'(4 * i));
      else        idle();
      mid();
      if (i > 0) check_eq("t6_wr_wen", 32'(sram_wen), 32'd0);
    end
    for (int i = 0; i < 16; i++) begin
      step(); bus.HWDATA = 32'h0; drive(T_NSEQ, 1'b0, 3'd2, 32'h800 + 32'(4 * i));
      mid();
      check_eq("t6_rd_cen", 32'(sram_cen), 32'd0);
      step(); drive(T_BUSY, 1'b0, 3'd2, 32'h804 + 32'(4 * i));
      mid();
      check_eq("t6_ready", 32'(bus.HREADYOUT), 32'd1);
      check_eq("t6_resp",  32'(bus.HRESP), 32'd0);
      check_eq("t6_data",  bus.HRDATA, 32'hC0DE_0000 + 32'(i));
      check_eq("t6_busy_cen", 32'(sram_cen), 32'd1);
    end
    step(); idle();
    mid();
    check_eq("t6_busy_ready", 32'(bus.HREADYOUT), 32'd1);
    check_eq("t6_busy_resp",  32'(bus.HRESP), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
